uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Byte FIFO directly downstream of the UART receiver (READER role). Captures each
//  completed byte strobed out of the receiver and holds it until the consumer pops it
//  over a valid/ready handshake. Decouples the bursty serial line from a slower consumer.
//  Flags overflow instead of stalling, because the serial line cannot be back-pressured.
// PARAMETERS
//  DATA_W   8    width of one entry (one UART character, LSB-first as received)
//  DEPTH    16   number of entries; power of two, >= 2
//  ADDR_W   $clog2(DEPTH)   derived localparam, not overridable
// PORTS
//  clk        in   1         single clock; all state updates on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  in_data    in   DATA_W    byte from UART receiver
//  in_valid   in   1         one-cycle strobe: in_data holds a complete byte
//  out_data   out  DATA_W    head-of-queue byte (first-word fall-through)
//  out_valid  out  1         head entry present
//  out_ready  in   1         consumer accepts head this cycle
//  count      out  ADDR_W+1  entries held, 0..DEPTH
//  full       out  1         count == DEPTH
//  empty      out  1         count == 0
//  overrun    out  1         sticky: a byte was dropped because the FIFO was full
//  clr_ovr    in   1         synchronous clear of overrun
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, out_valid=0,
//    overrun=0, out_data=0. Memory contents are not reset.
//  - Pointers are ADDR_W+1 bits; the MSB is the wrap bit. Full when the addresses are equal
//    and the wrap bits differ; empty when the pointers are equal. Addresses wrap DEPTH-1 -> 0.
//  - push = in_valid & (~full | pop); pop = out_valid & out_ready.
//  - Push: mem[wr_ptr] <= in_data; wr_ptr++.
//  - Pop: rd_ptr++.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Latency: a byte pushed at edge N is visible on out_valid/out_data after edge N.
//    There is no same-cycle bypass from in_* to out_*.
//  - out_data is driven from mem[rd_ptr]. It is stable while out_valid=1 and out_ready=0.
//  - out_valid == ~empty. Popping while out_valid=0 is ignored; no pointer change.
//  - Full with in_valid and pop in the same cycle: both happen, count stays DEPTH,
//    and no overrun is flagged.
//  - Full with in_valid and no pop: byte dropped, pointers unchanged, overrun <= 1.
//  - Empty with in_valid and out_ready in the same cycle: push only. The byte appears
//    next cycle.
//  - overrun: set has priority over clr_ovr in the same cycle. It clears only via clr_ovr
//    or reset.
//  - Reset asserted mid-burst: all queued bytes are discarded immediately, with no
//    partial pop.
// STRUCTURE
//  - Shared include uart_defs.vh: UART_DATA_W=8 and the default FIFO depth constant.
//    The UART core and this FIFO both use it.
//  - Sub-module uart_fifo_mem: DEPTH x DATA_W storage with one synchronous write port
//    and one asynchronous read port. Pointer, flag and overrun logic live in this module.
// TESTING
//  1 reset, then push 0x41,0x42,0x43 with out_ready=0 -> count=3, out_data=0x41,
//    out_valid=1, empty=0.
//  2 out_ready=1 for 3 cycles -> pops 0x41,0x42,0x43 in order; then empty=1,
//    out_valid=0, count=0.
//  3 push 16 bytes 0x00..0x0F, then a 17th byte 0xFF with out_ready=0 -> full=1,
//    count=16, overrun=1, drain yields 0x00..0x0F.
//  4 full, then in_valid=1 and out_ready=1 in the same cycle with 0xAA -> count=16,
//    overrun=0, 0xAA is the last byte drained.
//  5 interleave 40 push/pop pairs (pointer wrap twice) with random stall gaps ->
//    output sequence equals input sequence, count never exceeds 16.
//  6 push 5 bytes, pull rst_n low mid-cycle -> count=0, out_valid=0 immediately;
//    after release, push 0x63 ('c') -> out_data=0x63 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: character width and default receive FIFO depth,
// used by both the UART core and the receive FIFO.
package uart_rx_fifo_pkg;
  localparam int UART_DATA_W    = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  function automatic logic is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata = mem_reg[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: first-word fall-through head, no back-pressure
// toward the serial line, sticky overrun flag when a byte is dropped on a full queue.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  input  logic              clr_ovr
);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
  logic              overrun_reg, overrun_next;
  logic              push, pop, drop;
  logic [DATA_W-1:0] mem_rdata;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                 (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  assign out_valid = ~empty;
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    overrun_next = overrun_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    if (drop)         overrun_next = 1'b1;
    else if (clr_ovr) overrun_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      overrun_reg <= overrun_next;
    end
  end

  assign overrun = overrun_reg;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_reg[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // Stale memory is masked so the head reads as zero whenever the queue is empty.
  assign out_data = empty ? '0 : mem_rdata;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table for basic push/pop,
// then hand-written sequences for full, overrun, wrap and async reset.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       full, empty, overrun;
  logic       clr_ovr = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic [4:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_full;
    logic       e_ovr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    clr_ovr   = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovr   = 1'b0;
  endtask

  vec_t vecs [10];
  logic [7:0] q [$];
  logic [7:0] sent [$];
  logic [7:0] got [$];

  initial begin
    // in_valid, data, out_ready, clr_ovr | count, valid, data, full, overrun
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 5'd2, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 5'd3, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b1, 8'h42, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'h43, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 8'h66, 1'b0, 1'b0, 5'd1, 1'b1, 8'h66, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tests 1-2 plus empty-pop and empty push+pop corners
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      $display("vec %0d: iv=%0b d=%02h rdy=%0b -> count=%0d valid=%0b data=%02h",
               i, vecs[i].iv, vecs[i].d, vecs[i].rdy, count, out_valid, out_data);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(!vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain66_empty", 32'(empty), 32'd1);

    // Test 3: fill, then overflow with 0xFF
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    $display("fill: count=%0d full=%0b", count, full);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovr", 32'(overrun), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    $display("overflow 0xFF: count=%0d overrun=%0b head=%02h", count, overrun, out_data);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_ovr", 32'(overrun), 32'd1);
    chk("ovf_head", 32'(out_data), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovr", 32'(overrun), 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("ovr_set_prio", 32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovr2", 32'(overrun), 32'd0);

    // Test 4: push and pop together while full
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    $display("full push+pop 0xAA: count=%0d overrun=%0b", count, overrun);
    chk("fpp_count", 32'(count), 32'd16);
    chk("fpp_full", 32'(full), 32'd1);
    chk("fpp_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(out_data), (i < 15) ? 32'(i + 1) : 32'hAA);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Test 5: random interleave of 40 bytes against a queue model
    begin
      int cyc = 0;
      int n_sent = 0;
      while ((n_sent < 40 || q.size() > 0) && cyc < 2000) begin
        logic iv, rdy, mpop, mpush;
        logic [7:0] d;
        iv  = (n_sent < 40) && ($urandom_range(0, 2) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        d   = 8'($urandom);
        mpop  = (q.size() > 0) && rdy;
        mpush = iv && (q.size() < 16 || mpop);
        if (mpop) got.push_back(out_data);
        step(iv, d, rdy, 1'b0);
        if (mpop) void'(q.pop_front());
        if (mpush) begin
          q.push_back(d);
          sent.push_back(d);
          n_sent++;
        end
        chk("rnd_count", 32'(count), 32'(q.size()));
        if (q.size() > 0) chk("rnd_head", 32'(out_data), 32'(q[0]));
        cyc++;
      end
      chk("rnd_timeout", 32'(cyc < 2000), 32'd1);
      chk("rnd_len", 32'(got.size()), 32'(sent.size()));
      for (int i = 0; i < got.size() && i < sent.size(); i++)
        chk($sformatf("rnd_seq_%0d", i), 32'(got[i]), 32'(sent[i]));
      $display("random: %0d bytes sent, %0d received in %0d cycles", sent.size(), got.size(), cyc);
      chk("rnd_ovr", 32'(overrun), 32'd0);
    end

    // Test 6: async reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: count=%0d valid=%0b", count, out_valid);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h63, 1'b0, 1'b0);
    $display("post reset push 0x63: count=%0d data=%02h", count, out_data);
    chk("post_rst_data", 32'(out_data), 32'h63);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
